// File: rtl/mips5_pipeline.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with built-in instruction ROM,
// 32x32 register file and word-addressed data RAM.

package mips5_pkg;
  // Fibonacci demo: $2=1, $k=$(k-2)+$(k-1) for k=3..11, then mem[k-1]=$k.
  function automatic logic [2047:0] default_rom();
    logic [2047:0] img;
    img = '0;
    img[0 +: 32] = {6'h08, 5'd0, 5'd2, 16'd1};
    for (int k = 3; k <= 11; k++)
      img[32*(k-2) +: 32] = {6'h00, 5'(k-2), 5'(k-1), 5'(k), 5'd0, 6'h20};
    for (int k = 1; k <= 11; k++)
      img[32*(k+9) +: 32] = {6'h2B, 5'd0, 5'(k), 16'(4*(k-1))};
    return img;
  endfunction
endpackage

module mips5_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      registers[waddr] <= wdata;
    end
  end

  // Write-through so ID sees the value WB is committing this cycle.
  assign rd1 = (ra1 == 5'd0) ? '0 : (we && waddr == ra1) ? wdata : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (we && waddr == ra2) ? wdata : registers[ra2];
endmodule

module mips5_dmem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) memory[i] <= '0;
    end else if (we) begin
      memory[idx] <= wdata;
    end
  end

  assign rdata = memory[idx];
endmodule

module mips5_pipeline #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = (IMEM_WORDS*32)'(mips5_pkg::default_rom())
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] pc, instr_f;
  logic [31:0] ifid_instr, ifid_pc4;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_d, rf_rd1, rf_rd2;
  logic        d_regw, d_memr, d_memw, d_branch, d_alu_imm, d_uses_rs, d_uses_rt;
  logic [4:0]  d_dest;
  alu_op_t     d_aluop;
  logic        stall, taken, kill;

  logic        idex_regw, idex_memr, idex_memw, idex_branch, idex_alu_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc4;
  alu_op_t     idex_aluop;

  logic [31:0] fwd_a, fwd_b, alu_b, alu_y, target;

  logic        exmem_regw, exmem_memr, exmem_memw;
  logic [4:0]  exmem_dest;
  logic [31:0] exmem_alu, exmem_sdata, dmem_rdata;

  logic        memwb_regw, memwb_memr;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_alu, memwb_load, wb_data;

  logic        unused_bits;

  // Past the end of the ROM the core fetches NOPs rather than wrapping.
  always_comb begin
    instr_f = '0;
    if (pc[31:2] < 30'(IMEM_WORDS)) instr_f = ROM_IMAGE[{pc[IAW+1:2], 5'd0} +: 32];
  end

  assign op    = ifid_instr[31:26];
  assign rs    = ifid_instr[25:21];
  assign rt    = ifid_instr[20:16];
  assign rd    = ifid_instr[15:11];
  assign funct = ifid_instr[5:0];
  assign imm_d = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  always_comb begin
    d_regw = 1'b0; d_memr = 1'b0; d_memw = 1'b0; d_branch = 1'b0;
    d_alu_imm = 1'b0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
    d_dest = 5'd0; d_aluop = ALU_ADD;
    case (op)
      6'h00: begin
        d_uses_rs = 1'b1; d_uses_rt = 1'b1; d_dest = rd; d_regw = 1'b1;
        case (funct)
          6'h20: d_aluop = ALU_ADD;
          6'h22: d_aluop = ALU_SUB;
          6'h24: d_aluop = ALU_AND;
          6'h25: d_aluop = ALU_OR;
          6'h2A: d_aluop = ALU_SLT;
          default: begin d_regw = 1'b0; d_uses_rs = 1'b0; d_uses_rt = 1'b0; end
        endcase
      end
      6'h08: begin d_uses_rs = 1'b1; d_regw = 1'b1; d_alu_imm = 1'b1; d_dest = rt; end
      6'h23: begin d_uses_rs = 1'b1; d_regw = 1'b1; d_memr = 1'b1; d_alu_imm = 1'b1; d_dest = rt; end
      6'h2B: begin d_uses_rs = 1'b1; d_uses_rt = 1'b1; d_memw = 1'b1; d_alu_imm = 1'b1; end
      6'h04: begin d_uses_rs = 1'b1; d_uses_rt = 1'b1; d_branch = 1'b1; end
      default: ;
    endcase
  end

  assign stall = idex_memr && idex_dest != 5'd0 &&
                 ((d_uses_rs && idex_dest == rs) || (d_uses_rt && idex_dest == rt));

  mips5_regfile register_file (
    .clk(clk), .reset(reset),
    .we(memwb_regw), .waddr(memwb_dest), .wdata(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rf_rd1), .rd2(rf_rd2)
  );

  // EX/MEM result wins over MEM/WB; $0 destinations never forward.
  always_comb begin
    fwd_a = idex_a;
    if (exmem_regw && exmem_dest != 5'd0 && exmem_dest == idex_rs) fwd_a = exmem_alu;
    else if (memwb_regw && memwb_dest != 5'd0 && memwb_dest == idex_rs) fwd_a = wb_data;
    fwd_b = idex_b;
    if (exmem_regw && exmem_dest != 5'd0 && exmem_dest == idex_rt) fwd_b = exmem_alu;
    else if (memwb_regw && memwb_dest != 5'd0 && memwb_dest == idex_rt) fwd_b = wb_data;
  end

  assign alu_b = idex_alu_imm ? idex_imm : fwd_b;

  always_comb begin
    alu_y = fwd_a + alu_b;
    case (idex_aluop)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_y = fwd_a + alu_b;
    endcase
  end

  assign taken  = idex_branch && (fwd_a == fwd_b);
  assign target = idex_pc4 + (idex_imm << 2);
  assign kill   = taken || stall;

  mips5_dmem #(.WORDS(DMEM_WORDS)) data_memory (
    .clk(clk), .reset(reset),
    .we(exmem_memw), .idx(exmem_alu[DAW+1:2]),
    .wdata(exmem_sdata), .rdata(dmem_rdata)
  );

  assign wb_data = memwb_memr ? memwb_load : memwb_alu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0; ifid_instr <= '0; ifid_pc4 <= '0;
      idex_regw <= 1'b0; idex_memr <= 1'b0; idex_memw <= 1'b0; idex_branch <= 1'b0;
      idex_alu_imm <= 1'b0; idex_aluop <= ALU_ADD;
      idex_rs <= '0; idex_rt <= '0; idex_dest <= '0;
      idex_a <= '0; idex_b <= '0; idex_imm <= '0; idex_pc4 <= '0;
      exmem_regw <= 1'b0; exmem_memr <= 1'b0; exmem_memw <= 1'b0;
      exmem_dest <= '0; exmem_alu <= '0; exmem_sdata <= '0;
      memwb_regw <= 1'b0; memwb_memr <= 1'b0; memwb_dest <= '0;
      memwb_alu <= '0; memwb_load <= '0;
    end else begin
      if (taken) begin
        pc <= target; ifid_instr <= '0; ifid_pc4 <= '0;
      end else if (!stall) begin
        pc <= pc + 32'd4; ifid_instr <= instr_f; ifid_pc4 <= pc + 32'd4;
      end
      // A squashed or stalled slot enters EX as a bubble: controls cleared.
      idex_regw   <= d_regw && !kill;
      idex_memr   <= d_memr && !kill;
      idex_memw   <= d_memw && !kill;
      idex_branch <= d_branch && !kill;
      idex_dest   <= kill ? 5'd0 : d_dest;
      idex_alu_imm <= d_alu_imm; idex_aluop <= d_aluop;
      idex_rs <= rs; idex_rt <= rt;
      idex_a <= rf_rd1; idex_b <= rf_rd2; idex_imm <= imm_d; idex_pc4 <= ifid_pc4;
      exmem_regw <= idex_regw; exmem_memr <= idex_memr; exmem_memw <= idex_memw;
      exmem_dest <= idex_dest; exmem_alu <= alu_y; exmem_sdata <= fwd_b;
      memwb_regw <= exmem_regw; memwb_memr <= exmem_memr; memwb_dest <= exmem_dest;
      memwb_alu <= exmem_alu; memwb_load <= dmem_rdata;
    end
  end

  assign unused_bits = ^{pc[1:0], ifid_instr[10:6], exmem_alu[1:0], exmem_alu[31:DAW+2]};
endmodule

// File: tb/tb_mips5_pipeline.sv
// Bench for mips5_pipeline: three cores (default ROM, directed program, random
// program) checked against an instruction-level interpreter.

module tb_mips5_pipeline;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int funct);
    r_ins = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    i_ins = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [2047:0] def_image();
    logic [2047:0] img;
    int n;
    img = '0;
    n = 0;
    img[32*n +: 32] = i_ins(8, 0, 2, 1); n++;
    for (int k = 3; k <= 11; k++) begin img[32*n +: 32] = r_ins(k-2, k-1, k, 32); n++; end
    for (int k = 1; k <= 11; k++) begin img[32*n +: 32] = i_ins(43, 0, k, 4*(k-1)); n++; end
    return img;
  endfunction

  function automatic logic [2047:0] dir_image();
    logic [2047:0] img;
    img = '0;
    img[32*0  +: 32] = i_ins(8, 0, 1, 5);
    img[32*1  +: 32] = r_ins(1, 1, 2, 32);
    img[32*2  +: 32] = r_ins(2, 1, 3, 34);
    img[32*3  +: 32] = i_ins(8, 0, 14, 7);
    img[32*4  +: 32] = i_ins(43, 0, 14, 12);
    img[32*5  +: 32] = i_ins(35, 0, 4, 12);
    img[32*6  +: 32] = r_ins(4, 4, 5, 32);
    img[32*7  +: 32] = i_ins(4, 0, 0, 2);
    img[32*8  +: 32] = i_ins(8, 6, 6, 1);
    img[32*9  +: 32] = i_ins(8, 6, 6, 1);
    img[32*10 +: 32] = i_ins(8, 0, 7, 9);
    img[32*11 +: 32] = i_ins(4, 1, 0, 2);
    img[32*12 +: 32] = i_ins(8, 8, 8, 1);
    img[32*13 +: 32] = i_ins(8, 8, 8, 1);
    img[32*14 +: 32] = i_ins(8, 0, 0, 7);
    img[32*15 +: 32] = i_ins(8, 0, 10, -1);
    img[32*16 +: 32] = i_ins(8, 0, 11, 1);
    img[32*17 +: 32] = r_ins(10, 11, 12, 42);
    img[32*18 +: 32] = r_ins(11, 10, 13, 42);
    img[32*19 +: 32] = i_ins(43, 0, 3, 264);
    img[32*20 +: 32] = i_ins(35, 0, 15, 268);
    return img;
  endfunction

  function automatic logic [2047:0] rnd_image(input logic [31:0] seed);
    logic [2047:0] img;
    logic [31:0] x;
    int kind, r1, r2, r3, imm, mo;
    img = '0;
    x = seed;
    for (int i = 0; i < 48; i++) begin
      x = x ^ (x << 13); x = x ^ (x >> 17); x = x ^ (x << 5);
      kind = int'(x[3:0]);
      r1 = int'(x[6:4]); r2 = int'(x[9:7]); r3 = int'(x[12:10]);
      imm = int'($signed(x[17:13]));
      mo = 4 * int'(x[21:18]) + (x[22] ? 256 : 0);
      case (kind)
        0: img[32*i +: 32] = r_ins(r1, r2, r3, 32);
        1: img[32*i +: 32] = r_ins(r1, r2, r3, 34);
        2: img[32*i +: 32] = r_ins(r1, r2, r3, 36);
        3: img[32*i +: 32] = r_ins(r1, r2, r3, 37);
        4: img[32*i +: 32] = r_ins(r1, r2, r3, 42);
        5, 6: img[32*i +: 32] = i_ins(43, r2, r1, mo);
        7, 8: img[32*i +: 32] = i_ins(35, r2, r3, mo);
        9: img[32*i +: 32] = i_ins(4, int'(x[5:4]), int'(x[8:7]), int'(x[24:23]));
        default: img[32*i +: 32] = i_ins(8, r1, r3, imm);
      endcase
    end
    return img;
  endfunction

  localparam logic [2047:0] DEF_ROM = def_image();
  localparam logic [2047:0] DIR_ROM = dir_image();
  localparam logic [2047:0] RND_ROM = rnd_image(32'h1234_5678);

  logic clk = 1'b0;
  logic rst_def = 1'b1, rst_dir = 1'b1, rst_rnd = 1'b1;
  always #5 clk = ~clk;

  mips5_pipeline dut_def (.clk(clk), .reset(rst_def));
  mips5_pipeline #(.ROM_IMAGE(DIR_ROM)) dut_dir (.clk(clk), .reset(rst_dir));
  mips5_pipeline #(.ROM_IMAGE(RND_ROM)) dut_rnd (.clk(clk), .reset(rst_rnd));

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_reg [32];
  logic [31:0] exp_mem [64];
  int first_nz [32];

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic iss(input logic [2047:0] img);
    logic [31:0] pc, ins, a, b, imm, res;
    int rsn, rtn, rdn;
    for (int i = 0; i < 32; i++) exp_reg[i] = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    pc = 0;
    for (int step = 0; step < 500 && pc < 256; step++) begin
      ins = img[{pc[7:2], 5'd0} +: 32];
      rsn = int'(ins[25:21]); rtn = int'(ins[20:16]); rdn = int'(ins[15:11]);
      a = exp_reg[rsn]; b = exp_reg[rtn];
      imm = {{16{ins[15]}}, ins[15:0]};
      pc = pc + 4;
      case (ins[31:26])
        6'h00: begin
          res = 0;
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: rdn = 0;
          endcase
          if (rdn != 0) exp_reg[rdn] = res;
        end
        6'h08: if (rtn != 0) exp_reg[rtn] = a + imm;
        6'h23: if (rtn != 0) exp_reg[rtn] = exp_mem[((a + imm) / 4) % 64];
        6'h2B: exp_mem[((a + imm) / 4) % 64] = b;
        6'h04: if (a == b) pc = pc + imm * 4;
        default: ;
      endcase
    end
  endtask

  task automatic run_dir(input int ncyc);
    for (int r = 0; r < 32; r++) first_nz[r] = -1;
    @(negedge clk) rst_dir = 1'b0;
    @(negedge clk) rst_dir = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int r = 0; r < 32; r++)
        if (first_nz[r] < 0 && dut_dir.register_file.registers[r] != 0) first_nz[r] = c;
    end
  endtask

  task automatic test_reset();
    #1 rst_def = 1'b0; rst_dir = 1'b0; rst_rnd = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (dut_def.register_file.registers[i] !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg[%0d] got %h want 0", i, dut_def.register_file.registers[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (dut_rnd.data_memory.memory[i] !== 32'd0) begin
        n_bad++; $display("FAIL reset_mem[%0d] got %h want 0", i, dut_rnd.data_memory.memory[i]);
      end
    end
  endtask

  task automatic test_default_program();
    iss(DEF_ROM);
    @(negedge clk) rst_def = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (dut_def.data_memory.memory[10] !== 32'd55) begin
      n_bad++; $display("FAIL default_done_by_30 mem[10] got %0d want 55", dut_def.data_memory.memory[10]);
    end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (dut_def.register_file.registers[i] !== exp_reg[i]) begin
        n_bad++; $display("FAIL default_reg[%0d] got %0d want %0d", i, dut_def.register_file.registers[i], exp_reg[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (dut_def.data_memory.memory[i] !== exp_mem[i]) begin
        n_bad++; $display("FAIL default_mem[%0d] got %0d want %0d", i, dut_def.data_memory.memory[i], exp_mem[i]);
      end
    end
    n_cmp++;
    if (dut_def.register_file.registers[11] !== 32'd55) begin
      n_bad++; $display("FAIL default_fib11 got %0d want 55", dut_def.register_file.registers[11]);
    end
  endtask

  task automatic test_mid_reset();
    int at;
    iss(DEF_ROM);
    for (int it = 0; it < 2; it++) begin
      at = (it == 0) ? 10 : int'($urandom_range(5, 25));
      @(negedge clk) rst_def = 1'b0;
      @(negedge clk) rst_def = 1'b1;
      repeat (at) @(negedge clk);
      #2 rst_def = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut_def.register_file.registers[i] !== 32'd0) begin
          n_bad++; $display("FAIL midreset_reg[%0d] at %0d got %h want 0", i, at, dut_def.register_file.registers[i]);
        end
      end
      for (int i = 0; i < 64; i++) begin
        n_cmp++;
        if (dut_def.data_memory.memory[i] !== 32'd0) begin
          n_bad++; $display("FAIL midreset_mem[%0d] at %0d got %h want 0", i, at, dut_def.data_memory.memory[i]);
        end
      end
      @(negedge clk) rst_def = 1'b1;
      repeat (60) @(negedge clk);
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut_def.register_file.registers[i] !== exp_reg[i]) begin
          n_bad++; $display("FAIL rerun_reg[%0d] got %0d want %0d", i, dut_def.register_file.registers[i], exp_reg[i]);
        end
      end
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (dut_def.data_memory.memory[i] !== exp_mem[i]) begin
          n_bad++; $display("FAIL rerun_mem[%0d] got %0d want %0d", i, dut_def.data_memory.memory[i], exp_mem[i]);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    run_dir(40);
    n_cmp++;
    if (dut_dir.register_file.registers[2] !== 32'd10) begin
      n_bad++; $display("FAIL fwd_r2 got %0d want 10", dut_dir.register_file.registers[2]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[3] !== 32'd5) begin
      n_bad++; $display("FAIL fwd_r3 got %0d want 5", dut_dir.register_file.registers[3]);
    end
    n_cmp++;
    if (first_nz[1] < 0 || first_nz[2] - first_nz[1] !== 1 || first_nz[3] - first_nz[1] !== 2) begin
      n_bad++; $display("FAIL fwd_no_stall cycles r1=%0d r2=%0d r3=%0d want consecutive", first_nz[1], first_nz[2], first_nz[3]);
    end
  endtask

  task automatic test_load_use();
    run_dir(40);
    n_cmp++;
    if (dut_dir.register_file.registers[4] !== 32'd7) begin
      n_bad++; $display("FAIL lw_r4 got %0d want 7", dut_dir.register_file.registers[4]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[5] !== 32'd14) begin
      n_bad++; $display("FAIL loaduse_r5 got %0d want 14", dut_dir.register_file.registers[5]);
    end
    n_cmp++;
    if (first_nz[1] < 0 || first_nz[4] - first_nz[1] !== 5 || first_nz[5] - first_nz[1] !== 7) begin
      n_bad++; $display("FAIL loaduse_one_bubble offsets r4=%0d r5=%0d want 5 and 7",
                        first_nz[4] - first_nz[1], first_nz[5] - first_nz[1]);
    end
  endtask

  task automatic test_branch();
    run_dir(40);
    n_cmp++;
    if (dut_dir.register_file.registers[6] !== 32'd0) begin
      n_bad++; $display("FAIL beq_taken_flush r6 got %0d want 0", dut_dir.register_file.registers[6]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[7] !== 32'd9) begin
      n_bad++; $display("FAIL beq_target r7 got %0d want 9", dut_dir.register_file.registers[7]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[8] !== 32'd2) begin
      n_bad++; $display("FAIL beq_not_taken r8 got %0d want 2", dut_dir.register_file.registers[8]);
    end
  endtask

  task automatic test_zero_slt();
    iss(DIR_ROM);
    run_dir(40);
    n_cmp++;
    if (dut_dir.register_file.registers[0] !== 32'd0) begin
      n_bad++; $display("FAIL zero_reg got %0d want 0", dut_dir.register_file.registers[0]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[12] !== 32'd1) begin
      n_bad++; $display("FAIL slt_neg_lt_pos got %0d want 1", dut_dir.register_file.registers[12]);
    end
    n_cmp++;
    if (dut_dir.data_memory.memory[2] !== 32'd5) begin
      n_bad++; $display("FAIL sw_addr_wrap mem[2] got %0d want 5", dut_dir.data_memory.memory[2]);
    end
    n_cmp++;
    if (dut_dir.register_file.registers[15] !== 32'd7) begin
      n_bad++; $display("FAIL lw_addr_wrap r15 got %0d want 7", dut_dir.register_file.registers[15]);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (dut_dir.register_file.registers[i] !== exp_reg[i]) begin
        n_bad++; $display("FAIL directed_reg[%0d] got %h want %h", i, dut_dir.register_file.registers[i], exp_reg[i]);
      end
    end
  endtask

  task automatic test_random_program();
    iss(RND_ROM);
    for (int it = 0; it < 3; it++) begin
      @(negedge clk) rst_rnd = 1'b0;
      @(negedge clk) rst_rnd = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      #1 rst_rnd = 1'b0;
      @(negedge clk) rst_rnd = 1'b1;
      repeat (250) @(negedge clk);
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (dut_rnd.register_file.registers[i] !== exp_reg[i]) begin
          n_bad++; $display("FAIL random_reg[%0d] it%0d got %h want %h", i, it, dut_rnd.register_file.registers[i], exp_reg[i]);
        end
      end
      for (int i = 0; i < 64; i++) begin
        n_cmp++;
        if (dut_rnd.data_memory.memory[i] !== exp_mem[i]) begin
          n_bad++; $display("FAIL random_mem[%0d] it%0d got %h want %h", i, it, dut_rnd.data_memory.memory[i], exp_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_program();
    test_mid_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_zero_slt();
    test_random_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips5_pipeline.md
# mips5_pipeline

Five-stage pipelined MIPS-subset processor core (IF, ID, EX, MEM, WB) with built-in instruction ROM, a 32x32 register file and a 64-word data RAM. It is the top of the CPU subsystem: only clock and reset come in, and results are observed hierarchically in `register_file.registers[]` and `data_memory.memory[]`. The default ROM holds a Fibonacci program that verification checks after a fixed run time.

## Interface
- `IMEM_WORDS`, 64: instruction ROM depth (32-bit words).
- `DMEM_WORDS`, 64: data RAM depth (32-bit words).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all pipeline state.
- Required instance names: `register_file` (array `registers[0:31]`, 32-bit), `data_memory` (array `memory[0:DMEM_WORDS-1]`, 32-bit).

## Operation
- ISA: R-type `add, sub, and, or, slt` (funct 20,22,24,25,2A hex), `addi` (08), `lw` (23), `sw` (2B), `beq` (04). All-zero word is NOP. Other opcodes act as NOP.
- Arithmetic: 32-bit two's complement, wrap on overflow, no exceptions. `slt` signed. Immediates sign-extended.
- Memory addressing: byte address from ALU, word index = addr[7:2]; low bits ignored; index wraps modulo depth.
- `$0` reads 0 always; writes to it discarded.
- Register file: written at WB; a same-cycle read of the register being written returns the new value.
- Forwarding: EX operands take EX/MEM result first, then MEM/WB result, then ID/EX value; never forward from a destination of `$0`.
- Load-use hazard: instruction in ID using `rt`/`rs` of a `lw` in EX stalls one cycle (PC and IF/ID hold, bubble into ID/EX).
- `beq`: compared in EX; if taken, PC <= branch target (PC+4 + sext(imm)<<2), flush IF/ID and ID/EX (2-cycle penalty). Not-taken: no penalty.
- `sw` store data comes via forwarding path.
- Default ROM (word addresses 0..20, remainder NOP): `addi $2,$0,1`; then `add $k,$(k-2),$(k-1)` for k=3..11; then `sw $k,4*(k-1)($0)` for k=1..11.
- Data RAM and register file cleared to 0 on reset; ROM contents constant.

## Timing
- Reset asserted (low): PC=0, all pipeline registers = NOP bubble, registers and RAM = 0, effective immediately.
- First fetch at first rising edge after reset release; instruction retires (WB) 4 cycles after fetch.
- Throughput 1 instr/cycle absent stalls/flushes.
- Reset mid-run: all state returns to reset values asynchronously; execution restarts from PC 0.
- Store commits at MEM-stage clock edge; load data available to WB next cycle.
- Default program completes (last store written) within 30 cycles of reset release; PC then runs through NOPs, no further state change.

## Test plan
- Default program: release reset, run 60 cycles -> `$0..$11` = 0,0,1,1,2,3,5,8,13,21,34,55; memory[0..11] = 0,1,1,2,3,5,8,13,21,34,55,0.
- Forwarding: `addi $1,$0,5`; `add $2,$1,$1`; `sub $3,$2,$1` back-to-back -> $2=10, $3=5, no stall cycles.
- Load-use: `sw` 7 to mem[3], `lw $4,12($0)`; `add $5,$4,$4` -> $5=14, exactly one bubble inserted.
- Branch: `beq $0,$0,+2` followed by two `addi $6,$6,1` then `addi $7,$0,9` -> $6=0, $7=9; not-taken `beq` (unequal regs) executes both fall-through instrs.
- `$0` protection and `slt`: `addi $0,$0,7` -> $0 stays 0; `slt` with -1 vs 1 -> 1.
- Mid-run reset: pull reset low at cycle 10 -> all registers/memory read 0 immediately; after release, default program results match first scenario.
